// File: rtl/digit_scan_if.sv
// Bundle of display-side signals between the counter blocks, the digit scanner and the segment decoder.
interface digit_scan_if #(
  parameter int DIGITS   = 6,
  parameter int PWM_BITS = 4
);
  logic [4*DIGITS-1:0] digits_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                blank_lz;
  logic [DIGITS-1:0]   blink_mask;
  logic [PWM_BITS-1:0] brightness;
  logic [DIGITS-1:0]   digit_sel;
  logic [3:0]          seg_code;
  logic                dp_out;
  logic                frame_tick;

  modport master (
    output digits_in, dp_in, load, blank_lz, blink_mask, brightness,
    input  digit_sel, seg_code, dp_out, frame_tick
  );

  modport slave (
    input  digits_in, dp_in, load, blank_lz, blink_mask, brightness,
    output digit_sel, seg_code, dp_out, frame_tick
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scanner: frame-synchronous snapshot, leading-zero blanking,
// per-digit blink and PWM brightness; one registered output stage behind the scan state.
module digit_scan_ctrl #(
  parameter int DIGITS       = 6,
  parameter int SCAN_DIV     = 1024,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  digit_scan_if.slave bus
);
  localparam int SLOT_W = $clog2(DIGITS);
  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PRE_W-1:0]    prescaler_p0;
  logic [SLOT_W-1:0]   slot_p0;
  logic [PWM_BITS-1:0] pwm_cnt_p0;
  logic [BLK_W-1:0]    blink_cnt_p0;
  logic                blink_phase_p0;
  logic                pending_p0;
  logic [4*DIGITS-1:0] staging_dig_p0, shadow_dig_p0;
  logic [DIGITS-1:0]   staging_dp_p0, shadow_dp_p0;

  logic                slot_adv, frame_wrap;
  logic                all_zero;
  logic [DIGITS-1:0]   lz_blank;
  logic [DIGITS-1:0]   slot_onehot;
  logic [3:0]          cur_dig;
  logic                cur_dp, cur_blank;

  assign slot_adv   = (prescaler_p0 == PRE_W'(SCAN_DIV - 1));
  assign frame_wrap = slot_adv && (slot_p0 == SLOT_W'(DIGITS - 1));

  // Stage p0: scan position, PWM phase and blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_p0   <= '0;
      slot_p0        <= '0;
      pwm_cnt_p0     <= '0;
      blink_cnt_p0   <= '0;
      blink_phase_p0 <= 1'b0;
    end else begin
      if (slot_adv) begin
        prescaler_p0 <= '0;
        pwm_cnt_p0   <= '0;
        slot_p0      <= frame_wrap ? '0 : slot_p0 + SLOT_W'(1);
      end else begin
        prescaler_p0 <= prescaler_p0 + PRE_W'(1);
        pwm_cnt_p0   <= pwm_cnt_p0 + PWM_BITS'(1);
      end
      if (frame_wrap) begin
        if (blink_cnt_p0 == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_p0   <= '0;
          blink_phase_p0 <= ~blink_phase_p0;
        end else begin
          blink_cnt_p0 <= blink_cnt_p0 + BLK_W'(1);
        end
      end
    end
  end

  // Snapshot path: staging collects loads, shadow only changes at a frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_dig_p0 <= '0;
      staging_dp_p0  <= '0;
      shadow_dig_p0  <= '0;
      shadow_dp_p0   <= '0;
      pending_p0     <= 1'b0;
    end else if (frame_wrap) begin
      pending_p0 <= 1'b0;
      if (bus.load) begin
        shadow_dig_p0 <= bus.digits_in;
        shadow_dp_p0  <= bus.dp_in;
      end else if (pending_p0) begin
        shadow_dig_p0 <= staging_dig_p0;
        shadow_dp_p0  <= staging_dp_p0;
      end
    end else if (bus.load) begin
      staging_dig_p0 <= bus.digits_in;
      staging_dp_p0  <= bus.dp_in;
      pending_p0     <= 1'b1;
    end
  end

  // A slot is a leading zero when it and every slot above it hold zero
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero    = all_zero && (shadow_dig_p0[4*i +: 4] == 4'd0);
      lz_blank[i] = all_zero;
    end
  end

  always_comb begin
    slot_onehot = '0;
    cur_dig     = 4'hF;
    cur_dp      = 1'b0;
    cur_blank   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_p0 == SLOT_W'(i)) begin
        slot_onehot[i] = 1'b1;
        cur_dig        = shadow_dig_p0[4*i +: 4];
        cur_dp         = shadow_dp_p0[i];
        cur_blank      = (bus.blank_lz && lz_blank[i]) ||
                         (blink_phase_p0 && bus.blink_mask[i]);
      end
    end
  end

  // Stage p1: registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.digit_sel  <= '0;
      bus.seg_code   <= 4'hF;
      bus.dp_out     <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.frame_tick <= frame_wrap;
      if (cur_blank) begin
        bus.digit_sel <= '0;
        bus.seg_code  <= 4'hF;
        bus.dp_out    <= 1'b0;
      end else begin
        bus.digit_sel <= (pwm_cnt_p0 <= bus.brightness) ? slot_onehot : '0;
        bus.seg_code  <= cur_dig;
        bus.dp_out    <= cur_dp;
      end
    end
  end
endmodule
